// File: rtl/ccsds123_axis_out.sv
// -----------------------------------------------------------------------------
// ccsds123_axis_out
//
// Output stage of the CCSDS-123 compressor. Packed words from the encoder
// arrive with no backpressure and are buffered in a first-word-fall-through
// FIFO, then presented on an AXI-Stream master port. When the FIFO is full and
// the sink does not drain a word in the same cycle, the incoming word is
// dropped and the sticky overflow flag is raised until the next reset.
//
// Parameters:
//   BUS_WIDTH  width of each packed word (default 32)
//   DEPTH      number of FIFO entries, a power of two and at least 2 (default 16)
//
// Ports:
//   clk            single clock, all state changes on the rising edge
//   aresetn        asynchronous active-low reset
//   in_data        packed word from the encoder
//   in_valid       in_data valid this cycle
//   in_last        final word of the compressed image, qualified by in_valid
//   m_axis_tdata   AXI-Stream data (entry at the read pointer)
//   m_axis_tvalid  AXI-Stream valid, high whenever the FIFO is not empty
//   m_axis_tready  AXI-Stream ready from the sink
//   m_axis_tlast   AXI-Stream last, the in_last flag stored with the word
//   word_count     words popped since reset or since the last tlast word
//                  (present only with CCSDS123_AXIS_OUT_WORD_COUNT_EN)
//   overflow       sticky: at least one input word was dropped
//
// Build option:
//   CCSDS123_AXIS_OUT_WORD_COUNT_EN  adds the 32-bit word_count output
// -----------------------------------------------------------------------------
module ccsds123_axis_out #(
    parameter int BUS_WIDTH = 32,
    parameter int DEPTH     = 16
) (
    input  logic                 clk,
    input  logic                 aresetn,
    input  logic [BUS_WIDTH-1:0] in_data,
    input  logic                 in_valid,
    input  logic                 in_last,
    output logic [BUS_WIDTH-1:0] m_axis_tdata,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic                 m_axis_tlast,
`ifdef CCSDS123_AXIS_OUT_WORD_COUNT_EN
    output logic [31:0]          word_count,
`endif
    output logic                 overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [AW-1:0] PTR_ONE    = AW'(1);
    localparam logic [CW-1:0] COUNT_ONE  = CW'(1);
    localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);

    // Each entry carries the last flag in its top bit above the data word.
    logic [BUS_WIDTH:0] mem [DEPTH];

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [BUS_WIDTH:0] head;
    logic push;
    logic pop;

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a
    // word when the sink is draining; this keeps count steady at DEPTH.
    always_comb begin
        pop  = m_axis_tvalid && m_axis_tready;
        push = in_valid && ((count != COUNT_FULL) || pop);
    end

    // Outputs come straight from the head entry so a word written on one edge
    // is visible in the following cycle. The last flag is masked by valid so
    // it reads 0 while the FIFO is empty or held in reset, because stale
    // memory is never cleared.
    always_comb begin
        head          = mem[rd_ptr];
        m_axis_tvalid = (count != '0);
        m_axis_tdata  = head[BUS_WIDTH-1:0];
        m_axis_tlast  = m_axis_tvalid && head[BUS_WIDTH];
    end

    // Storage array has no reset: after reset the pointers and count make any
    // leftover contents unreachable.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {in_last, in_data};
        end
    end

    // Pointer, occupancy and overflow bookkeeping. Pointers are exactly AW
    // bits wide, so they wrap modulo DEPTH on their own. A word is dropped
    // only when valid input finds the FIFO full with no pop, which is exactly
    // the case where push stays low; overflow then latches for good.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (push && !pop) begin
                count <= count + COUNT_ONE;
            end else if (pop && !push) begin
                count <= count - COUNT_ONE;
            end
            if (in_valid && !push) begin
                overflow <= 1'b1;
            end
        end
    end

`ifdef CCSDS123_AXIS_OUT_WORD_COUNT_EN
    // Counts words handed to the sink within the current image. The pop that
    // carries tlast closes the image, so the counter restarts from zero for
    // the next one instead of including that word.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            word_count <= '0;
        end else if (pop) begin
            if (m_axis_tlast) begin
                word_count <= '0;
            end else begin
                word_count <= word_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ccsds123_axis_out.sv
// -----------------------------------------------------------------------------
// tb_ccsds123_axis_out
//
// Self-checking bench for ccsds123_axis_out with BUS_WIDTH=32, DEPTH=16.
// Inputs are driven on the falling edge and outputs are sampled 1 ns later,
// well away from the rising edge where the DUT updates.
// -----------------------------------------------------------------------------
module tb_ccsds123_axis_out;

    localparam int BW    = 32;
    localparam int DEPTH = 16;

    logic          clk;
    logic          aresetn;
    logic [BW-1:0] in_data;
    logic          in_valid;
    logic          in_last;
    logic [BW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic          m_axis_tlast;
    logic          overflow;
`ifdef CCSDS123_AXIS_OUT_WORD_COUNT_EN
    logic [31:0]   word_count;
`endif

    int n_compared;
    int n_mismatched;

    ccsds123_axis_out #(
        .BUS_WIDTH(BW),
        .DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .aresetn(aresetn),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_last(in_last),
        .m_axis_tdata(m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tlast(m_axis_tlast),
`ifdef CCSDS123_AXIS_OUT_WORD_COUNT_EN
        .word_count(word_count),
`endif
        .overflow(overflow)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic          in_valid;
        logic [BW-1:0] in_data;
        logic          in_last;
        logic          tready;
        logic          exp_tvalid;
        logic [BW-1:0] exp_tdata;
        logic          exp_tlast;
        logic          exp_overflow;
    } vec_t;

    vec_t vecs[7];

    // Drive one cycle of inputs on the falling edge.
    task automatic applyStimulus(input logic v, input logic [BW-1:0] d,
                                 input logic l, input logic r);
        @(negedge clk);
        in_valid      = v;
        in_data       = d;
        in_last       = l;
        m_axis_tready = r;
    endtask

    // Compare one observed value against its expected value.
    task automatic checkOutput(input string name, input logic [BW-1:0] actual,
                               input logic [BW-1:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    // Hold reset for two cycles and release on a falling edge so the next
    // rising edge is the first one that can accept a push.
    task automatic doReset();
        aresetn       = 1'b0;
        in_valid      = 1'b0;
        in_data       = '0;
        in_last       = 1'b0;
        m_axis_tready = 1'b0;
        repeat (2) @(negedge clk);
        aresetn = 1'b1;
    endtask

    int            q[$];
    int            sent;
    int            received;
    int            cycles;
    logic          stalled;
    logic [BW-1:0] held_data;
    logic          held_last;
    int            exp_word;

    initial begin
        n_compared   = 0;
        n_mismatched = 0;

        // Four-word stream with sink always ready: each word appears one
        // cycle after it is pushed and tlast rides only with 0x3.
        vecs[0] = '{1'b1, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 32'h1, 1'b0, 1'b1, 1'b1, 32'h0, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 32'h2, 1'b0, 1'b1, 1'b1, 32'h1, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 32'h3, 1'b1, 1'b1, 1'b1, 32'h2, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 32'hFF, 1'b1, 1'b1, 1'b1, 32'h3, 1'b1, 1'b0};
        vecs[5] = '{1'b0, 32'hAA, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0};
        vecs[6] = '{1'b0, 32'h55, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0};

        doReset();
        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i].in_valid, vecs[i].in_data,
                          vecs[i].in_last, vecs[i].tready);
            #1;
            checkOutput("vec_tvalid", BW'(m_axis_tvalid), BW'(vecs[i].exp_tvalid));
            checkOutput("vec_tlast", BW'(m_axis_tlast), BW'(vecs[i].exp_tlast));
            checkOutput("vec_overflow", BW'(overflow), BW'(vecs[i].exp_overflow));
            if (vecs[i].exp_tvalid) begin
                checkOutput("vec_tdata", m_axis_tdata, vecs[i].exp_tdata);
            end
        end

        // Fill with sink stalled, then a 17th word must be dropped.
        $display("[TB] overflow sequence");
        doReset();
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b1, 32'h100 + i, 1'b0, 1'b0);
        end
        applyStimulus(1'b1, 32'hDEAD, 1'b0, 1'b0);
        #1;
        checkOutput("full_overflow_before", BW'(overflow), 32'h0);
        checkOutput("full_head", m_axis_tdata, 32'h100);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        checkOutput("full_overflow_set", BW'(overflow), 32'h1);
        checkOutput("full_head_held", m_axis_tdata, 32'h100);
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
            #1;
            checkOutput("drain_tvalid", BW'(m_axis_tvalid), 32'h1);
            checkOutput("drain_tdata", m_axis_tdata, 32'h100 + i);
        end
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
        #1;
        checkOutput("drain_empty", BW'(m_axis_tvalid), 32'h0);
        checkOutput("overflow_sticky", BW'(overflow), 32'h1);

        // Full FIFO with a pop and a push on the same edge keeps every word.
        $display("[TB] full push+pop sequence");
        doReset();
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b1, 32'h200 + i, 1'b0, 1'b0);
        end
        applyStimulus(1'b1, 32'hBEEF, 1'b0, 1'b1);
        #1;
        checkOutput("pp_tvalid", BW'(m_axis_tvalid), 32'h1);
        checkOutput("pp_head", m_axis_tdata, 32'h200);
        for (int i = 1; i < DEPTH; i++) begin
            applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
            #1;
            checkOutput("pp_drain", m_axis_tdata, 32'h200 + i);
        end
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
        #1;
        checkOutput("pp_beef", m_axis_tdata, 32'hBEEF);
        checkOutput("pp_beef_valid", BW'(m_axis_tvalid), 32'h1);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
        #1;
        checkOutput("pp_empty", BW'(m_axis_tvalid), 32'h0);
        checkOutput("pp_no_overflow", BW'(overflow), 32'h0);

        // Random sink stalls and input bubbles against a queue model.
        $display("[TB] random stream");
        doReset();
        q.delete();
        sent     = 0;
        received = 0;
        cycles   = 0;
        stalled  = 1'b0;
        while (received < 256 && cycles < 4000) begin
            if (sent < 256 && q.size() < DEPTH && $urandom_range(0, 3) != 0) begin
                applyStimulus(1'b1, BW'(sent), (sent == 255), ($urandom_range(0, 2) != 0));
            end else begin
                applyStimulus(1'b0, BW'($urandom), 1'($urandom), ($urandom_range(0, 2) != 0));
            end
            #1;
            checkOutput("rand_tvalid", BW'(m_axis_tvalid), BW'(q.size() != 0));
            if (stalled && m_axis_tvalid) begin
                checkOutput("rand_hold_data", m_axis_tdata, held_data);
                checkOutput("rand_hold_last", BW'(m_axis_tlast), BW'(held_last));
            end
            if (m_axis_tvalid && m_axis_tready && q.size() != 0) begin
                exp_word = q.pop_front();
                checkOutput("rand_tdata", m_axis_tdata, BW'(exp_word));
                checkOutput("rand_tlast", BW'(m_axis_tlast), BW'(exp_word == 255));
                received++;
            end
            stalled   = m_axis_tvalid && !m_axis_tready;
            held_data = m_axis_tdata;
            held_last = m_axis_tlast;
            if (in_valid) begin
                q.push_back(sent);
                sent++;
            end
            cycles++;
        end
        checkOutput("rand_received", BW'(received), 32'd256);
        checkOutput("rand_no_overflow", BW'(overflow), 32'h0);

        // Asynchronous reset mid-stream drops all buffered words.
        $display("[TB] mid-stream reset");
        doReset();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 32'h300 + i, 1'b1, 1'b0);
        end
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        checkOutput("pre_rst_tvalid", BW'(m_axis_tvalid), 32'h1);
        checkOutput("pre_rst_tlast", BW'(m_axis_tlast), 32'h1);
        #1;
        aresetn = 1'b0;
        #1;
        checkOutput("rst_tvalid", BW'(m_axis_tvalid), 32'h0);
        checkOutput("rst_tlast", BW'(m_axis_tlast), 32'h0);
        checkOutput("rst_overflow", BW'(overflow), 32'h0);
        @(negedge clk);
        aresetn = 1'b1;
        applyStimulus(1'b1, 32'h7, 1'b1, 1'b1);
        #1;
        checkOutput("post_rst_empty", BW'(m_axis_tvalid), 32'h0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
        #1;
        checkOutput("post_rst_valid", BW'(m_axis_tvalid), 32'h1);
        checkOutput("post_rst_data", m_axis_tdata, 32'h7);
        checkOutput("post_rst_last", BW'(m_axis_tlast), 32'h1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
            #1;
            checkOutput("post_rst_drained", BW'(m_axis_tvalid), 32'h0);
        end

`ifdef CCSDS123_AXIS_OUT_WORD_COUNT_EN
        // Ten-word image: counter reads 1..9 after each pop, 0 after tlast.
        $display("[TB] word count");
        doReset();
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 32'h400 + i, (i == 9), 1'b0);
        end
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        checkOutput("wc_start", word_count, 32'd0);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
            @(posedge clk);
            #1;
            checkOutput("wc_value", word_count, (i == 9) ? 32'd0 : 32'(i + 1));
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/ccsds123_axis_out.md
CCSDS123_AXIS_OUT -- requirements
Module: ccsds123_axis_out

Interface
REQ-001 Parameter BUS_WIDTH, default 32, width of each packed output word from the encoder.
REQ-002 Parameter DEPTH, default 16, number of FIFO entries; power of two, >= 2.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 aresetn  input  1  reset, asynchronous and active-low.
REQ-005 in_data  input  BUS_WIDTH  packed word from the encoder stage.
REQ-006 in_valid  input  1  in_data valid this cycle; producer has no backpressure.
REQ-007 in_last  input  1  marks the final word of the compressed image; qualified by in_valid.
REQ-008 m_axis_tdata  output  BUS_WIDTH  AXI-Stream data.
REQ-009 m_axis_tvalid  output  1  AXI-Stream valid.
REQ-010 m_axis_tready  input  1  AXI-Stream ready from the sink.
REQ-011 m_axis_tlast  output  1  AXI-Stream last; the in_last flag stored with the word.
REQ-012 overflow  output  1  sticky flag: at least one input word was dropped.

Function
REQ-013 The block SHALL buffer words in a FIFO of DEPTH entries, each BUS_WIDTH+1 bits wide (data plus last flag).
REQ-014 The occupancy count SHALL be clog2(DEPTH)+1 bits; read and write pointers SHALL wrap modulo DEPTH.
REQ-015 Push SHALL occur when in_valid=1 and (count<DEPTH or a pop occurs in the same cycle).
REQ-016 Pop SHALL occur when m_axis_tvalid=1 and m_axis_tready=1.
REQ-017 Simultaneous push and pop SHALL leave count unchanged; this holds at count=DEPTH and at count=1.
REQ-018 When in_valid=1, count=DEPTH and no pop occurs, the word SHALL be discarded, pointers and count unchanged, and overflow SHALL be set on that edge.
REQ-019 overflow SHALL remain 1 until reset; no other clear path exists.
REQ-020 m_axis_tvalid SHALL equal (count!=0); m_axis_tdata/m_axis_tlast SHALL present the entry at the read pointer (first-word fall-through).
REQ-021 Latency: a word pushed on edge N into an empty FIFO SHALL appear on m_axis_tvalid/tdata in the cycle following edge N.
REQ-022 While m_axis_tvalid=1 and m_axis_tready=0, m_axis_tdata and m_axis_tlast SHALL hold stable (AXI-Stream rule).
REQ-023 Words SHALL leave in arrival order; no word SHALL be duplicated or reordered.
REQ-024 in_last SHALL be stored verbatim; no framing, padding or word generation is performed by this block.
REQ-025 in_data and in_last SHALL be ignored when in_valid=0.

Reset
REQ-026 Asserting aresetn=0 SHALL immediately clear pointers, count and overflow, regardless of clock.
REQ-027 During reset m_axis_tvalid=0, m_axis_tlast=0, overflow=0; m_axis_tdata value is don't-care.
REQ-028 Reset mid-stream SHALL discard all buffered words; FIFO memory contents need not be cleared.
REQ-029 The first push SHALL be possible on the first rising edge after aresetn deasserts.

Configuration
REQ-030 Macro CCSDS123_AXIS_OUT_WORD_COUNT_EN, when defined, SHALL add output word_count (32 bits): count of words popped since reset, incremented per pop, wrapping at 2^32, cleared on the pop carrying tlast=1 (value 0 in the cycle after), reset to 0.
REQ-031 Without the macro the word_count port and its counter SHALL not exist; all other behaviour identical.

Verification
REQ-032 Reset, then 4 words 0x0..0x3 with in_valid=1, tready=1, last on 0x3 -> output 0x0..0x3 in order, each one cycle after input, tlast only with 0x3, overflow=0.
REQ-033 tready=0, push 16 words (DEPTH=16) then a 17th 0xDEAD -> count stays 16, 0xDEAD never output, overflow=1 on that edge and stays 1.
REQ-034 FIFO full, tready=1 and in_valid=1 on same cycle with 0xBEEF -> one pop, 0xBEEF accepted, count stays 16, overflow stays 0.
REQ-035 Random tready (approx. 33% low) over 256 words 0..255 with in_valid bubbles -> output equals input order, tdata stable whenever tvalid=1 and tready=0.
REQ-036 Assert aresetn=0 with 5 words buffered -> m_axis_tvalid=0 immediately; after release, push 0x7 -> only 0x7 output.
REQ-037 With CCSDS123_AXIS_OUT_WORD_COUNT_EN: pop 10 words, last on 10th -> word_count reads 9 after 9 pops, 0 after the tlast pop.
